// File: rtl/tri_host_driver.sv
// Host-side driver for a triangle rasterizer: buffers three vertices, streams
// them out in three back-to-back cycles, then captures the rasterizer's inside
// pixels into a 64-bit bitmap and counts the distinct ones.
//
// Handshake: a vertex is taken on any rising edge where wr_en=1, full=0 and the
// FSM is in IDLE or LOAD; otherwise the write is dropped with no back-pressure.
// The rasterizer sees nt=1 for exactly one cycle (SEND1) followed by two more
// vertex cycles. busy=1 acknowledges the triangle and qualifies po/xo/yo;
// busy falling back to 0 ends the frame.
module tri_host_driver #(
  parameter int TIMEOUT = 8,
  parameter int MAXRUN  = 80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_x,
  input  logic [2:0] wr_y,
  output logic       full,
  input  logic       clr,
  output logic       nt,
  output logic [2:0] xi,
  output logic [2:0] yi,
  input  logic       busy,
  input  logic       po,
  input  logic [2:0] xo,
  input  logic [2:0] yo,
  output logic       done,
  output logic       err,
  output logic [6:0] pix_cnt,
  input  logic [5:0] rd_addr,
  output logic       rd_data,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WAIT_IDLE, S_SEND1, S_SEND2, S_SEND3, S_ARM, S_RUN, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        vcnt_q, vcnt_d;     // vertices held in the buffer
  logic [2:0][5:0]   vert_q, vert_d;     // each entry packed as {y, x}
  logic [6:0]        cyc_q, cyc_d;       // ARM / RUN watchdog counter
  logic              err_q, err_d;
  logic [6:0]        pix_q, pix_d;
  logic [63:0]       bitmap_q, bitmap_d;
  logic              wr_ok;
  logic [5:0]        pix_addr;

  // State register and datapath flops; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      vcnt_q   <= '0;
      vert_q   <= '0;
      cyc_q    <= '0;
      err_q    <= 1'b0;
      pix_q    <= '0;
      bitmap_q <= '0;
    end else begin
      state_q  <= state_d;
      vcnt_q   <= vcnt_d;
      vert_q   <= vert_d;
      cyc_q    <= cyc_d;
      err_q    <= err_d;
      pix_q    <= pix_d;
      bitmap_q <= bitmap_d;
    end
  end

  // Next-state logic: vertex loading, send sequencing, watchdogs, pixel capture.
  always_comb begin
    state_d  = state_q;
    vcnt_d   = vcnt_q;
    vert_d   = vert_q;
    cyc_d    = cyc_q;
    err_d    = err_q;
    pix_d    = pix_q;
    bitmap_d = bitmap_q;
    pix_addr = {yo, xo};
    wr_ok    = wr_en && (vcnt_q != 2'd3) &&
               ((state_q == S_IDLE) || (state_q == S_LOAD));

    if (wr_ok) begin
      vert_d[vcnt_q] = {wr_y, wr_x};
      vcnt_d         = vcnt_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        // clr is applied before an accompanying write is taken
        if (clr) begin
          bitmap_d = '0;
          pix_d    = '0;
          err_d    = 1'b0;
        end
        if (wr_ok) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (wr_ok && (vcnt_q == 2'd2)) state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (!busy) begin
          state_d  = S_SEND1;
          bitmap_d = '0;
          pix_d    = '0;
        end
      end
      S_SEND1: state_d = S_SEND2;
      S_SEND2: state_d = S_SEND3;
      S_SEND3: begin
        state_d = S_ARM;
        cyc_d   = '0;
      end
      S_ARM: begin
        if (busy) begin
          state_d = S_RUN;
          cyc_d   = '0;
        end else if (cyc_q == 7'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
          vcnt_d  = '0;
        end else begin
          cyc_d = cyc_q + 7'd1;
        end
      end
      S_RUN: begin
        if (!busy) begin
          state_d = S_DONE;
          vcnt_d  = '0;
        end else begin
          if (po) begin
            bitmap_d[pix_addr] = 1'b1;
            if (!bitmap_q[pix_addr] && (pix_q < 7'd64)) pix_d = pix_q + 7'd1;
          end
          if (cyc_q == 7'(MAXRUN - 1)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
            vcnt_d  = '0;
          end else begin
            cyc_d = cyc_q + 7'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Vertex bus to the rasterizer: driven only during the three send cycles.
  always_comb begin
    nt = 1'b0;
    xi = '0;
    yi = '0;
    case (state_q)
      S_SEND1: begin
        nt       = 1'b1;
        {yi, xi} = vert_q[0];
      end
      S_SEND2: {yi, xi} = vert_q[1];
      S_SEND3: {yi, xi} = vert_q[2];
      default: ;
    endcase
  end

  assign full      = (vcnt_q == 2'd3);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign pix_cnt   = pix_q;
  assign rd_data   = bitmap_q[rd_addr];
  assign state_dbg = state_q;

endmodule
